acq_sequencer: RTL and testbench

- Sequences one acquisition run from the host-written configuration: `cpu_trig` (pulse), `repetitions`, `samples` and `generator_hops` from the command-decode FSM.
- Runs nested loops: outer over generator hops, inner over repetitions. Each repetition triggers the ADC capture path and counts `samples` accepted samples.
- Between hops it asks the signal generator to step and waits for its acknowledge.
- Sits between the command-decode FSM and the ADC-capture / generator-control blocks.

---
 rtl/acq_pkg.sv | 21 ++
 rtl/acq_timeout_ctr.sv | 36 +++
 rtl/acq_sequencer.sv | 171 +++++++++++++++++
 tb/tb_acq_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer.
package acq_pkg;

    localparam int unsigned CNT_W_DEF = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_NEXT_REP,
        S_HOP_REQ,
        S_HOP_WAIT,
        S_DONE
    } acq_state_e;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_CFG    = 2'd1;
    localparam logic [1:0] ERR_GEN_TO = 2'd2;
    localparam logic [1:0] ERR_ABORT  = 2'd3;

endpackage

// File: rtl/acq_timeout_ctr.sv
// Clearable up-counter that saturates at TERM-1 and flags the terminal count.
module acq_timeout_ctr #(
    parameter int unsigned TERM = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W    = (TERM > 1) ? $clog2(TERM) : 1;
    localparam logic [W-1:0] LAST = W'(TERM - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition run sequencer: hop loop around a repetition loop, each repetition
// triggering the ADC and counting accepted samples.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned GEN_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_trig,
    input  logic [CNT_W-1:0] repetitions,
    input  logic [CNT_W-1:0] samples,
    input  logic [CNT_W-1:0] generator_hops,
    input  logic             abort,
    input  logic             adc_valid,
    input  logic             gen_ack,
    output logic             busy,
    output logic             adc_trig,
    output logic             capture_en,
    output logic             gen_step,
    output logic [CNT_W-1:0] sample_index,
    output logic [CNT_W-1:0] rep_index,
    output logic [CNT_W-1:0] hop_index,
    output logic             done,
    output logic [1:0]       err_code
);

    acq_state_e state_q, state_d;

    logic [CNT_W-1:0] reps_q, reps_d;
    logic [CNT_W-1:0] smps_q, smps_d;
    logic [CNT_W-1:0] hops_q, hops_d;
    logic [CNT_W-1:0] sidx_q, sidx_d;
    logic [CNT_W-1:0] ridx_q, ridx_d;
    logic [CNT_W-1:0] hidx_q, hidx_d;
    logic [1:0]       err_q, err_d;

    logic tmr_clr, tmr_en, tmr_tc;

    acq_timeout_ctr #(
        .TERM (GEN_TIMEOUT)
    ) u_gen_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        reps_d     = reps_q;
        smps_d     = smps_q;
        hops_d     = hops_q;
        sidx_d     = sidx_q;
        ridx_d     = ridx_q;
        hidx_d     = hidx_q;
        err_d      = err_q;
        adc_trig   = 1'b0;
        capture_en = 1'b0;
        gen_step   = 1'b0;
        done       = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_trig) begin
                    reps_d = repetitions;
                    smps_d = samples;
                    hops_d = (generator_hops == '0) ? CNT_W'(1) : generator_hops;
                    sidx_d = '0;
                    ridx_d = '0;
                    hidx_d = '0;
                    if ((repetitions == '0) || (samples == '0)) begin
                        err_d   = ERR_CFG;
                        state_d = S_DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                adc_trig = 1'b1;
                sidx_d   = '0;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                capture_en = 1'b1;
                if (adc_valid) begin
                    sidx_d = sidx_q + CNT_W'(1);
                    if (sidx_q == smps_q - CNT_W'(1)) begin
                        state_d = S_NEXT_REP;
                    end
                end
            end
            S_NEXT_REP: begin
                if (ridx_q < reps_q - CNT_W'(1)) begin
                    ridx_d  = ridx_q + CNT_W'(1);
                    state_d = S_ARM;
                end else if (hidx_q == hops_q - CNT_W'(1)) begin
                    err_d   = ERR_OK;
                    state_d = S_DONE;
                end else begin
                    ridx_d  = '0;
                    state_d = S_HOP_REQ;
                end
            end
            S_HOP_REQ: begin
                gen_step = 1'b1;
                tmr_clr  = 1'b1;
                state_d  = S_HOP_WAIT;
            end
            S_HOP_WAIT: begin
                tmr_en = 1'b1;
                if (gen_ack) begin
                    hidx_d  = hidx_q + CNT_W'(1);
                    state_d = S_ARM;
                end else if (tmr_tc) begin
                    err_d   = ERR_GEN_TO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any index update this cycle so the counts freeze where they were.
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            sidx_d  = sidx_q;
            ridx_d  = ridx_q;
            hidx_d  = hidx_q;
            err_d   = ERR_ABORT;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            reps_q  <= '0;
            smps_q  <= '0;
            hops_q  <= '0;
            sidx_q  <= '0;
            ridx_q  <= '0;
            hidx_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            reps_q  <= reps_d;
            smps_q  <= smps_d;
            hops_q  <= hops_d;
            sidx_q  <= sidx_d;
            ridx_q  <= ridx_d;
            hidx_q  <= hidx_d;
            err_q   <= err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign sample_index = sidx_q;
    assign rep_index    = ridx_q;
    assign hop_index    = hidx_q;
    assign err_code     = err_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: vector table of whole runs plus hand-written
// sequences for re-trigger, config change, adc_valid gaps and mid-run reset.
module tb_acq_sequencer;

    localparam int unsigned CW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_trig;
    logic [CW-1:0] repetitions, samples, generator_hops;
    logic          abort, adc_valid, gen_ack;
    logic          busy, adc_trig, capture_en, gen_step, done;
    logic [CW-1:0] sample_index, rep_index, hop_index;
    logic [1:0]    err_code;

    acq_sequencer #(
        .CNT_W       (CW),
        .GEN_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_trig       (cpu_trig),
        .repetitions    (repetitions),
        .samples        (samples),
        .generator_hops (generator_hops),
        .abort          (abort),
        .adc_valid      (adc_valid),
        .gen_ack        (gen_ack),
        .busy           (busy),
        .adc_trig       (adc_trig),
        .capture_en     (capture_en),
        .gen_step       (gen_step),
        .sample_index   (sample_index),
        .rep_index      (rep_index),
        .hop_index      (hop_index),
        .done           (done),
        .err_code       (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_trig   = 0;
    int n_samp   = 0;
    int n_step   = 0;
    int n_done   = 0;
    int ack_delay = -1;

    always @(negedge clk) begin
        if (adc_trig)   n_trig <= n_trig + 1;
        if (gen_step)   n_step <= n_step + 1;
        if (done)       n_done <= n_done + 1;
        if (capture_en && adc_valid && !abort) n_samp <= n_samp + 1;
    end

    // Generator model: acknowledges ack_delay cycles after each gen_step; never when negative.
    initial begin
        int cd;
        cd = 0;
        gen_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            gen_ack = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) gen_ack = 1'b1;
            end
            @(negedge clk);
            if (gen_step && (ack_delay > 0)) cd = ack_delay;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle 1 is the one carrying cpu_trig; done_k is the cycle where done is seen (-1 if never).
    task automatic drive_run(input int reps, input int smp, input int hops, input int ackd,
                             input int abort_at, input bit gaps, input bit retrig,
                             input int budget, output int done_k);
        int snap;
        ack_delay = ackd;
        @(posedge clk); #1;
        repetitions    = CW'(reps);
        samples        = CW'(smp);
        generator_hops = CW'(hops);
        cpu_trig       = 1'b1;
        snap           = n_samp;
        done_k         = -1;
        for (int k = 2; k <= budget; k++) begin
            @(posedge clk); #1;
            cpu_trig = retrig && (k == 4);
            if (retrig && (k == 3)) begin
                repetitions    = CW'(5);
                samples        = CW'(9);
                generator_hops = CW'(3);
            end
            adc_valid = gaps ? ((k % 3) != 0) : 1'b1;
            abort     = (abort_at >= 0) && capture_en && ((n_samp - snap) == abort_at);
            @(negedge clk);
            if (done) begin
                done_k = k;
                break;
            end
        end
        @(posedge clk); #1;
        adc_valid = 1'b0;
        abort     = 1'b0;
        cpu_trig  = 1'b0;
    endtask

    typedef struct {
        string name;
        int reps, smp, hops, ackd, abort_at;
        int exp_k, exp_trig, exp_samp, exp_step, exp_err;
        int exp_sidx, exp_ridx, exp_hidx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dk, t0, s0, g0, d0;
        //            name      reps smp hops ack abort  k trig samp step err sidx ridx hidx
        vecs[0] = '{"minimal",   1,   1,   1,  4,  -1,   5,  1,   1,   0,  0,   1,   0,   0};
        vecs[1] = '{"full",      2,   3,   2,  4,  -1,  27,  4,  12,   1,  0,   3,   1,   1};
        vecs[2] = '{"zero_smp",  2,   0,   1,  4,  -1,   2,  0,   0,   0,  1,   0,   0,   0};
        vecs[3] = '{"zero_rep",  0,   5,   1,  4,  -1,   2,  0,   0,   0,  1,   0,   0,   0};
        vecs[4] = '{"hops0",     1,   2,   0,  4,  -1,   6,  1,   2,   0,  0,   2,   0,   0};
        vecs[5] = '{"timeout",   1,   1,   2, -1,  -1,  22,  1,   1,   1,  2,   1,   0,   0};
        vecs[6] = '{"three_hop", 1,   1,   3,  1,  -1,  15,  3,   3,   2,  0,   1,   0,   2};
        vecs[7] = '{"abort",     1, 100,   1,  4,  10,  14,  1,  10,   0,  3,  10,   0,   0};

        rst_n = 1'b0; cpu_trig = 1'b0; abort = 1'b0; adc_valid = 1'b0;
        repetitions = '0; samples = '0; generator_hops = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {busy, adc_trig, capture_en, gen_step, done, err_code},
              32'd0);
        check("reset_indices", 32'(sample_index | rep_index | hop_index), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            t0 = n_trig; s0 = n_samp; g0 = n_step;
            drive_run(vecs[i].reps, vecs[i].smp, vecs[i].hops, vecs[i].ackd,
                      vecs[i].abort_at, 1'b0, 1'b0, 300, dk);
            check({vecs[i].name, "_done_cycle"}, dk, vecs[i].exp_k);
            check({vecs[i].name, "_trigs"},   n_trig - t0, vecs[i].exp_trig);
            check({vecs[i].name, "_samples"}, n_samp - s0, vecs[i].exp_samp);
            check({vecs[i].name, "_steps"},   n_step - g0, vecs[i].exp_step);
            check({vecs[i].name, "_err"},     err_code,     vecs[i].exp_err);
            check({vecs[i].name, "_sidx"},    sample_index, vecs[i].exp_sidx);
            check({vecs[i].name, "_ridx"},    rep_index,    vecs[i].exp_ridx);
            check({vecs[i].name, "_hidx"},    hop_index,    vecs[i].exp_hidx);
            check({vecs[i].name, "_idle_after"}, {busy, done, capture_en}, 32'd0);
        end

        // Re-trigger in CAPTURE and config change after start must not disturb the run.
        t0 = n_trig; s0 = n_samp; d0 = n_done;
        drive_run(2, 3, 1, 4, -1, 1'b1, 1'b1, 100, dk);
        check("retrig_done_cycle", dk, 15);
        check("retrig_trigs", n_trig - t0, 2);
        check("retrig_samples", n_samp - s0, 6);
        check("retrig_err", err_code, 0);
        check("retrig_indices", {rep_index[7:0], sample_index[7:0]}, {8'd1, 8'd3});
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("retrig_one_done", n_done - d0, 1);
        check("retrig_idle", busy, 0);

        // Asynchronous reset while waiting for the generator acknowledge.
        ack_delay = -1;
        @(posedge clk); #1;
        repetitions = CW'(1); samples = CW'(1); generator_hops = CW'(2);
        cpu_trig = 1'b1; adc_valid = 1'b1;
        @(posedge clk); #1;
        cpu_trig = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hopwait_busy", {busy, sample_index[7:0]}, {1'b1, 8'd1});
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {busy, adc_trig, capture_en, gen_step, done, err_code}, 32'd0);
        check("async_rst_indices", 32'(sample_index | rep_index | hop_index), 32'd0);
        adc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("async_rst_no_done", n_done - d0, 0);
        t0 = n_trig; s0 = n_samp;
        drive_run(1, 1, 1, 4, -1, 1'b0, 1'b0, 50, dk);
        check("post_rst_done_cycle", dk, 5);
        check("post_rst_run", {8'(n_trig - t0), 8'(n_samp - s0), 6'd0, err_code}, {8'd1, 8'd1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
